// File: rtl/spi_pkg.sv
// Shared widths, register map and FSM state type for the SPI register-bus initiator.
package spi_pkg;

   localparam int FRAME_W = 16;
   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 8;
   localparam logic RW_WRITE = 1'b1;

   localparam logic [ADDR_W-1:0] REG_OUT_7_0  = 7'h00;
   localparam logic [ADDR_W-1:0] REG_OUT_15_8 = 7'h01;
   localparam logic [ADDR_W-1:0] REG_PWM_7_0  = 7'h02;
   localparam logic [ADDR_W-1:0] REG_PWM_15_8 = 7'h03;
   localparam logic [ADDR_W-1:0] REG_DUTY     = 7'h04;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } spi_state_e;

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK half-period timer: rise/fall strobes fire on the last cycle of a half period,
// one cycle before the registered sclk output toggles.
module spi_sclk_div #(
   parameter int CLK_DIV = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic rise_stb,
   output logic fall_stb
);

   logic [7:0] cnt;
   logic       phase;
   logic       tick;

   // phase=0 means sclk is currently low, so the next strobe is a rise.
   assign tick     = en && (cnt == 8'(CLK_DIV - 1));
   assign rise_stb = tick && !phase;
   assign fall_stb = tick && phase;

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (tick) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt   <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/spi_controller.sv
// SPI Mode 0 initiator sending one 16-bit [rw|addr|data] frame per request, MSB first.
// Define SPI_CTRL_READBACK_EN to add cipo capture for read frames (rd_data/rd_valid).
module spi_controller
   import spi_pkg::*;
#(
   parameter int CLK_DIV    = 5,
   parameter int GAP_CYCLES = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic              busy,
   output logic              done,
   output logic              sclk,
   output logic              copi,
   output logic              ncs,
`ifdef SPI_CTRL_READBACK_EN
   input  logic              cipo,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
`endif
   output spi_state_e        state_dbg
);

   if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_clk_div
      $error("spi_controller: CLK_DIV must be within 4..255");
   end
   if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
      $error("spi_controller: GAP_CYCLES must be within 1..255");
   end

   spi_state_e           state, state_nxt;
   logic [FRAME_W-2:0]   rest_q;
   logic [3:0]           bit_cnt;
   logic [7:0]           gap_cnt;
   logic                 accept;
   logic                 div_en, rise_stb, fall_stb, hold_end;
   logic                 ncs_d, sclk_d, copi_d, done_d, ready_d, busy_d;

   assign accept    = req_valid && req_ready;
   assign div_en    = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
   assign hold_end  = rise_stb || fall_stb;
   assign state_dbg = state;

   spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk      (clk),
      .rst      (rst),
      .en       (div_en),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // SHIFT covers both halves of every bit; the last low half ends on a rise strobe.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (accept) state_nxt = ST_SETUP;
         ST_SETUP: if (rise_stb) state_nxt = ST_SHIFT;
         ST_SHIFT: if (rise_stb && bit_cnt == 4'd15) state_nxt = ST_HOLD;
         ST_HOLD:  if (hold_end) state_nxt = ST_GAP;
         ST_GAP:   if (gap_cnt == 8'(GAP_CYCLES - 1)) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ncs_d   = ncs;
      sclk_d  = sclk;
      copi_d  = copi;
      done_d  = 1'b0;
      ready_d = (state_nxt == ST_IDLE);
      busy_d  = (state_nxt != ST_IDLE);
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               ncs_d  = 1'b0;
               copi_d = req_rw;
            end
         end
         ST_SETUP: if (rise_stb) sclk_d = 1'b1;
         ST_SHIFT: begin
            if (rise_stb && bit_cnt != 4'd15) begin
               sclk_d = 1'b1;
            end else if (fall_stb) begin
               sclk_d = 1'b0;
               copi_d = (bit_cnt == 4'd15) ? 1'b0 : rest_q[FRAME_W-2];
            end
         end
         ST_HOLD: begin
            if (hold_end) begin
               ncs_d  = 1'b1;
               done_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ncs       <= 1'b1;
         sclk      <= 1'b0;
         copi      <= 1'b0;
         done      <= 1'b0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
      end else begin
         ncs       <= ncs_d;
         sclk      <= sclk_d;
         copi      <= copi_d;
         done      <= done_d;
         req_ready <= ready_d;
         busy      <= busy_d;
      end
   end

   // Bit 15 goes straight to copi on accept, so only the remaining 15 bits are kept.
   always_ff @(posedge clk) begin
      if (rst) begin
         rest_q  <= '0;
         bit_cnt <= '0;
         gap_cnt <= '0;
      end else begin
         if (accept) begin
            rest_q  <= {req_addr, req_data};
            bit_cnt <= '0;
         end else if (state == ST_SHIFT) begin
            if (fall_stb) rest_q <= {rest_q[FRAME_W-3:0], 1'b0};
            if (rise_stb && bit_cnt != 4'd15) bit_cnt <= bit_cnt + 4'd1;
         end
         gap_cnt <= (state == ST_GAP) ? gap_cnt + 8'd1 : 8'd0;
      end
   end

`ifdef SPI_CTRL_READBACK_EN
   logic              rw_q;
   logic              rise_q;
   logic [DATA_W-1:0] rd_shift;

   // rise_q marks the first cycle sclk is high, where cipo is sampled for bits 8..15.
   always_ff @(posedge clk) begin
      if (rst) begin
         rw_q     <= RW_WRITE;
         rise_q   <= 1'b0;
         rd_shift <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rise_q   <= sclk_d && !sclk;
         rd_valid <= 1'b0;
         if (accept) rw_q <= req_rw;
         if (rise_q && bit_cnt[3] && rw_q != RW_WRITE)
            rd_shift <= {rd_shift[DATA_W-2:0], cipo};
         if (done_d && rw_q != RW_WRITE) begin
            rd_data  <= rd_shift;
            rd_valid <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: two instances (CLK_DIV 5 and 4) watched by a serial-line
// peripheral model; frames, timing and register effects are checked against the request stream.
module tb_spi_controller;
   import spi_pkg::*;

   localparam int N   = 2;
   localparam int GAP = 5;

   typedef struct {
      logic [15:0] frame;
      int          bits;
      int          low;
      int          high_before;
      int          fall_cyc;
      logic        done_at_rise;
      logic [7:0]  rdd;
      logic        rdv;
   } rec_t;

   typedef struct {
      logic        rw;
      logic [6:0]  addr;
      logic [7:0]  data;
      logic [15:0] exp_frame;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic       req_valid [N];
   logic       req_ready [N];
   logic       req_rw    [N];
   logic [6:0] req_addr  [N];
   logic [7:0] req_data  [N];
   logic       busy [N];
   logic       done [N];
   logic       sclk [N];
   logic       copi [N];
   logic       ncs  [N];
   spi_state_e state_dbg [N];
`ifdef SPI_CTRL_READBACK_EN
   logic       cipo     [N];
   logic [7:0] rd_data  [N];
   logic       rd_valid [N];
   logic [7:0] rd_pat   [N];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      spi_controller #(.CLK_DIV(g == 0 ? 5 : 4), .GAP_CYCLES(GAP)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_rw    (req_rw[g]),
         .req_addr  (req_addr[g]),
         .req_data  (req_data[g]),
         .busy      (busy[g]),
         .done      (done[g]),
         .sclk      (sclk[g]),
         .copi      (copi[g]),
         .ncs       (ncs[g]),
`ifdef SPI_CTRL_READBACK_EN
         .cipo      (cipo[g]),
         .rd_data   (rd_data[g]),
         .rd_valid  (rd_valid[g]),
`endif
         .state_dbg (state_dbg[g])
      );
   end

   // Monitor / peripheral model state (written only by the monitor process).
   logic        prev_ncs [N];
   logic        prev_sclk [N];
   logic        prev_copi [N];
   logic        held_copi [N];
   logic [15:0] cur_shf [N];
   int          cur_bits [N];
   int          low_cnt [N];
   int          high_cnt [N];
   int          high_at_fall [N];
   int          fall_cyc [N];
   int          rise_hi_err [N];
   int          copi_err [N];
   int          done_err [N];
   int          done_cnt [N];
   logic [7:0]  pregs [N][5];
   int          cyc;
   rec_t        obs0[$];
   rec_t        obs1[$];

   // Expected state (written only by the main process).
   logic [7:0]  exp_regs [N][5];
   logic [15:0] exp_q[$];
   int          frames_exp [N];
   int          checks, errors;

   initial begin
      rec_t mr;
      cyc = 0;
      for (int i = 0; i < N; i++) begin
         prev_ncs[i] = 1'b1; prev_sclk[i] = 1'b0; prev_copi[i] = 1'b0; held_copi[i] = 1'b0;
         cur_shf[i] = '0; cur_bits[i] = 0; low_cnt[i] = 0; high_cnt[i] = 1000;
         high_at_fall[i] = 0; fall_cyc[i] = 0; rise_hi_err[i] = 0; copi_err[i] = 0;
         done_err[i] = 0; done_cnt[i] = 0;
         for (int k = 0; k < 5; k++) pregs[i][k] = 8'h00;
`ifdef SPI_CTRL_READBACK_EN
         cipo[i] = 1'b0;
`endif
      end
      forever begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < N; i++) begin
            if (prev_ncs[i] && !ncs[i]) begin
               cur_bits[i] = 0; cur_shf[i] = '0; low_cnt[i] = 0;
               fall_cyc[i] = cyc; high_at_fall[i] = high_cnt[i];
            end
            if (!ncs[i]) low_cnt[i]++;
            if (!prev_sclk[i] && sclk[i]) begin
               if (ncs[i]) rise_hi_err[i]++;
               cur_shf[i]   = {cur_shf[i][14:0], copi[i]};
               cur_bits[i]++;
               held_copi[i] = copi[i];
            end else if (prev_sclk[i] && sclk[i] && copi[i] !== held_copi[i]) begin
               copi_err[i]++;
            end else if (!prev_sclk[i] && !sclk[i] && !ncs[i] && !prev_ncs[i] && copi[i] !== prev_copi[i]) begin
               copi_err[i]++;
            end
`ifdef SPI_CTRL_READBACK_EN
            // Peripheral shifts its read byte out on sclk falling edges, MSB first.
            if (prev_sclk[i] && !sclk[i])
               cipo[i] = (cur_bits[i] >= 8 && cur_bits[i] < 16) ? rd_pat[i][15 - cur_bits[i]] : 1'b0;
            if (ncs[i]) cipo[i] = 1'b0;
`endif
            if (done[i]) begin
               done_cnt[i]++;
               if (!(ncs[i] && !prev_ncs[i])) done_err[i]++;
            end
            if (!prev_ncs[i] && ncs[i]) begin
               mr.frame = cur_shf[i]; mr.bits = cur_bits[i]; mr.low = low_cnt[i];
               mr.high_before = high_at_fall[i]; mr.fall_cyc = fall_cyc[i]; mr.done_at_rise = done[i];
`ifdef SPI_CTRL_READBACK_EN
               mr.rdd = rd_data[i]; mr.rdv = rd_valid[i];
`else
               mr.rdd = 8'h00; mr.rdv = 1'b0;
`endif
               if (i == 0) obs0.push_back(mr);
               else        obs1.push_back(mr);
               if (cur_bits[i] == 16 && cur_shf[i][15] && cur_shf[i][14:8] <= 7'd4)
                  pregs[i][int'(cur_shf[i][10:8])] = cur_shf[i][7:0];
               high_cnt[i] = 1;
            end else if (ncs[i]) begin
               high_cnt[i]++;
            end
            prev_ncs[i] = ncs[i]; prev_sclk[i] = sclk[i]; prev_copi[i] = copi[i];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic void model_apply(input int i, input logic [15:0] f);
      if (f[15] == RW_WRITE && f[14:8] <= 7'd4) exp_regs[i][int'(f[10:8])] = f[7:0];
   endfunction

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d, input bit hold);
      int n;
      n = 0;
      while (!req_ready[i] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[i]) begin
         checks++; errors++;
         $display("FAIL send_ready_timeout inst=%0d got=0 exp=1", i);
      end
      req_valid[i] = 1'b1; req_rw[i] = rw; req_addr[i] = a; req_data[i] = d;
      @(negedge clk);
      if (!hold) req_valid[i] = 1'b0;
   endtask

   task automatic get_rec(input int i, output rec_t r, output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      r  = '{default: 0};
      while (!ok && n < 3000) begin
         if (i == 0 && obs0.size() > 0) begin r = obs0.pop_front(); ok = 1'b1; end
         else if (i == 1 && obs1.size() > 0) begin r = obs1.pop_front(); ok = 1'b1; end
         else begin @(negedge clk); n++; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL frame_timeout inst=%0d got=none exp=frame", i);
      end
   endtask

   task automatic chk_frame(input string name, input int i, input logic [15:0] exp_f);
      rec_t r;
      bit   ok;
      get_rec(i, r, ok);
      if (ok) begin
         chk({name, "_frame"}, r.frame, exp_f);
         chk({name, "_bits"},  r.bits, 16);
         chk({name, "_ncs_low"}, r.low, 34 * (i == 0 ? 5 : 4));
         chk({name, "_done"}, r.done_at_rise, 1);
         model_apply(i, exp_f);
         frames_exp[i]++;
      end
   endtask

   initial begin
      vec_t tv [5];
      rec_t r, r2;
      bit   ok;
      int   dc;
      logic [15:0] exp_f;
      logic rw_r;
      logic [6:0] a_r;
      logic [7:0] d_r;

      checks = 0; errors = 0;
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = 1'b0; req_rw[i] = 1'b0; req_addr[i] = '0; req_data[i] = '0;
         frames_exp[i] = 0;
         for (int k = 0; k < 5; k++) exp_regs[i][k] = 8'h00;
`ifdef SPI_CTRL_READBACK_EN
         rd_pat[i] = 8'h00;
`endif
      end
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < N; i++) begin
         chk("rst_ncs", ncs[i], 1);
         chk("rst_sclk", sclk[i], 0);
         chk("rst_copi", copi[i], 0);
         chk("rst_ready", req_ready[i], 1);
         chk("rst_busy", busy[i], 0);
         chk("rst_done", done[i], 0);
         chk("rst_state", state_dbg[i], ST_IDLE);
`ifdef SPI_CTRL_READBACK_EN
         chk("rst_rd_data", rd_data[i], 0);
         chk("rst_rd_valid", rd_valid[i], 0);
`endif
      end

      tv[0] = '{1'b1, 7'h00, 8'hA5, 16'h80A5};
      tv[1] = '{1'b1, 7'h01, 8'h3C, 16'h813C};
      tv[2] = '{1'b1, 7'h03, 8'h12, 16'h8312};
      tv[3] = '{1'b0, 7'h02, 8'h77, 16'h0277};
      tv[4] = '{1'b1, 7'h7F, 8'hC3, 16'hFFC3};
      for (int v = 0; v < 5; v++) begin
         send(0, tv[v].rw, tv[v].addr, tv[v].data, 1'b0);
         chk_frame("vec", 0, tv[v].exp_frame);
      end
      chk("out_7_0_a5", pregs[0][0], 8'hA5);

      // Back-to-back with req_valid held across done.
      send(0, 1'b1, 7'h04, 8'h80, 1'b1);
      req_addr[0] = 7'h02; req_data[0] = 8'hFF;
      get_rec(0, r, ok);
      dc = 0;
      while (!req_ready[0] && dc < 400) begin @(negedge clk); dc++; end
      @(negedge clk);
      req_valid[0] = 1'b0;
      get_rec(0, r2, ok);
      if (ok) begin
         chk("b2b_frame1", r.frame, 16'h8480);
         chk("b2b_frame2", r2.frame, 16'h82FF);
         chk("b2b_fall_to_fall", r2.fall_cyc - r.fall_cyc, 34 * 5 + GAP + 1);
         chk("b2b_ncs_high", r2.high_before, GAP + 1);
         model_apply(0, 16'h8480); model_apply(0, 16'h82FF);
         frames_exp[0] += 2;
      end
      chk("duty_80", pregs[0][4], 8'h80);
      chk("pwm_7_0_ff", pregs[0][2], 8'hFF);

      // Reset after 7 sclk rising edges aborts the frame.
      send(0, 1'b1, 7'h01, 8'h55, 1'b0);
      dc = 0;
      while (cur_bits[0] < 7 && dc < 400) begin @(negedge clk); dc++; end
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_ncs", ncs[0], 1);
      chk("abort_sclk", sclk[0], 0);
      chk("abort_copi", copi[0], 0);
      chk("abort_ready", req_ready[0], 1);
      @(negedge clk);
      rst = 1'b0;
      dc = done_cnt[0];
      get_rec(0, r, ok);
      if (ok) begin
         chk("abort_bits", r.bits, 7);
         chk("abort_no_done", r.done_at_rise, 0);
      end
      repeat (200) @(negedge clk);
      chk("abort_done_count", done_cnt[0], dc);
      chk("abort_out_15_8_kept", pregs[0][1], 8'h3C);

      // Inputs wiggled while busy must not disturb the frame or cause an accept.
      send(0, 1'b1, 7'h02, 8'h5A, 1'b0);
      for (int k = 0; k < 150; k++) begin
         req_valid[0] = 1'($urandom_range(0, 1));
         req_rw[0]    = 1'($urandom_range(0, 1));
         req_addr[0]  = 7'($urandom);
         req_data[0]  = 8'($urandom);
         @(negedge clk);
      end
      req_valid[0] = 1'b0;
      chk_frame("busy_ignore", 0, 16'h825A);
      repeat (30) @(negedge clk);
      chk("no_extra_accept", obs0.size(), 0);
      chk("no_extra_ncs", ncs[0], 1);

      // Second instance: CLK_DIV=4, valid write then out-of-range address.
      send(1, 1'b1, 7'h02, 8'h44, 1'b0);
      chk_frame("div4_valid", 1, 16'h8244);
      send(1, 1'b1, 7'h05, 8'h99, 1'b0);
      chk_frame("div4_bad_addr", 1, 16'h8599);

      // Randomised frames through the scoreboard.
      for (int k = 0; k < 20; k++) begin
         rw_r = ($urandom_range(0, 3) != 0);
         a_r  = 7'($urandom_range(0, 6));
         d_r  = 8'($urandom);
         exp_q.push_back({rw_r, a_r, d_r});
         send(0, rw_r, a_r, d_r, 1'b0);
         get_rec(0, r, ok);
         exp_f = exp_q.pop_front();
         if (ok) begin
            chk("rand_frame", r.frame, exp_f);
            chk("rand_ncs_low", r.low, 170);
            model_apply(0, exp_f);
            frames_exp[0]++;
         end
      end

`ifdef SPI_CTRL_READBACK_EN
      rd_pat[0] = 8'h3C;
      send(0, 1'b0, 7'h03, 8'h00, 1'b0);
      get_rec(0, r, ok);
      if (ok) begin
         chk("rd_frame", r.frame, 16'h0300);
         chk("rd_valid_at_done", r.rdv, 1);
         chk("rd_data_3c", r.rdd, 8'h3C);
         frames_exp[0]++;
      end
      rd_pat[0] = 8'hE1;
      send(0, 1'b1, 7'h00, 8'h11, 1'b0);
      get_rec(0, r, ok);
      if (ok) begin
         chk("wr_no_rd_valid", r.rdv, 0);
         chk("wr_rd_data_held", r.rdd, 8'h3C);
         model_apply(0, 16'h8011);
         frames_exp[0]++;
      end
`endif

      repeat (20) @(negedge clk);
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < 5; k++) chk($sformatf("reg_i%0d_a%0d", i, k), pregs[i][k], exp_regs[i][k]);
         chk("rise_with_ncs_high", rise_hi_err[i], 0);
         chk("copi_unstable", copi_err[i], 0);
         chk("done_misplaced", done_err[i], 0);
         chk("done_count", done_cnt[i], frames_exp[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI Mode 0 initiator that drives SCLK, COPI and nCS toward the chip's SPI register peripheral.
- Serialises one 16-bit frame per accepted request: [R/W(1) | ADDR(7) | DATA(8)], MSB first.
- Used by on-chip test/bring-up logic and by the loopback bench to program the output-enable, PWM-enable and duty-cycle registers.
- SCLK is derived from clk by a programmable divider. It stays slow enough for the peripheral's 2-FF synchroniser and edge detector.

Parameters:
- CLK_DIV, 5, SCLK half-period in clk cycles (default gives 1 MHz from 10 MHz); legal range 4..255; elaboration assertion if outside.
- GAP_CYCLES, 5, minimum nCS-high cycles between frames; legal range 1..255.

Ports:
- clk  in  1  system clock, 10 MHz.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle; request accepted on req_valid & req_ready.
- req_rw  in  1  frame bit 15 (1 = write).
- req_addr  in  7  frame bits 14:8.
- req_data  in  8  frame bits 7:0.
- busy  out  1  high from accept until the end of GAP.
- done  out  1  one-cycle pulse when nCS returns high.
- sclk  out  1  SPI clock, idle low.
- copi  out  1  serial data to peripheral.
- ncs  out  1  chip select, active low.

Behaviour:
- Reset (rst=1 at a clk edge) sets: ncs=1, sclk=0, copi=0, req_ready=1, busy=0, done=0; state=IDLE; counters cleared.
- Reset mid-frame aborts the frame with no done pulse. The peripheral sees nCS rise with fewer than 16 bits and ignores the frame.
- All outputs are registered.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE: req_ready=1. On accept, capture {req_rw,req_addr,req_data} into a 16-bit shift register. Input changes after accept have no effect.
  - Next cycle: ncs=0, copi=frame[15], busy=1, req_ready=0; go to SETUP.
- SETUP: sclk low for CLK_DIV cycles, then go to SHIFT.
- SHIFT: 16 bit periods. Each period is sclk high for CLK_DIV cycles, then sclk low for CLK_DIV cycles.
  - copi changes only on the same cycle sclk falls, presenting the next bit.
  - copi is stable for the whole high phase and across each rising edge.
  - Bit counter runs 0..15. After the 16th falling edge, go to HOLD; copi is driven 0.
- HOLD: sclk low for CLK_DIV cycles. Then ncs=1, done=1 for one cycle; go to GAP.
- GAP: GAP_CYCLES cycles with ncs high. Then req_ready=1, busy=0; go to IDLE.
- Frame timing: nCS low for exactly 34*CLK_DIV cycles (170 at default). Accept-to-next-accept is at least 1 + 34*CLK_DIV + GAP_CYCLES.
- Exactly 16 sclk rising edges occur per frame, all with ncs=0.
- req_valid while busy is ignored; no queueing.
- A request held valid across done is accepted on the first IDLE cycle.
- Invalid addresses (>0x04) and read frames are transmitted unchanged. Filtering is the peripheral's job.

Optional Feature:
- Macro: SPI_CTRL_READBACK_EN.
- Defined:
  - Adds input cipo (1 bit) and outputs rd_data (8 bits) and rd_valid (1 bit).
  - For frames with rw=0, cipo is sampled on the clk cycle sclk rises, during bits 8..15, MSB first.
  - rd_data updates and rd_valid pulses on the same cycle as done.
  - rd_data holds until the next read frame. Reset value of rd_data and rd_valid is 0.
  - Write frames do not touch rd_data.
- Undefined: ports are absent and read frames are sent write-only with no capture.

Decomposition:
- Package spi_pkg holds:
  - FRAME_W=16, ADDR_W=7, DATA_W=8, RW_WRITE=1'b1.
  - Register address constants 0x00..0x04 (out_7_0, out_15_8, pwm_7_0, pwm_15_8, duty).
  - State enum type.
- One sub-module, spi_sclk_div: half-period counter with enable, producing rise/fall strobes one cycle ahead of the sclk toggle.
- FSM and shift register stay in spi_controller.

Test Plan:
- Write 0x00 data 0xA5 with default params -> frame bits on copi sampled at sclk rise are 0x80A5; ncs low 170 cycles; 16 rising edges; done once; loopback peripheral en_reg_out_7_0=0xA5.
- Back-to-back writes: 0x04/0x80 then 0x02/0xFF with req_valid held -> second accepted the first IDLE cycle after GAP; duty=0x80, pwm_7_0=0xFF; ncs high ≥5 cycles between frames.
- rst pulsed after 7 sclk rising edges -> next cycle ncs=1, sclk=0, copi=0; no done; peripheral registers unchanged.
- Change req_addr/req_data during SHIFT and toggle req_valid while busy -> transmitted frame equals captured value; no extra accept.
- CLK_DIV=4 and write to 0x05 -> frame timing 136 cycles; peripheral ignores it; all registers unchanged.
- With SPI_CTRL_READBACK_EN, read 0x03 with cipo model returning 0x3C -> rd_data=0x3C, rd_valid coincident with done.
